// File: rtl/bus_arbiter_if.sv
// Bus arbiter interface: groups the master request/grant signals and the
// shared-bus signals toward the slave. The arbiter connects through the
// slave modport; the masters and the bus slave connect through the master modport.
interface bus_arbiter_if #(
    parameter int N_MASTERS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [N_MASTERS-1:0]        m_req;
    logic [N_MASTERS-1:0]        m_we;
    logic [N_MASTERS*ADDR_W-1:0] m_addr;
    logic [N_MASTERS*DATA_W-1:0] m_wdata;
    logic [N_MASTERS-1:0]        m_gnt;
    logic [N_MASTERS-1:0]        m_ack;
    logic [DATA_W-1:0]           m_rdata;
    logic                        m_err;
    logic [ADDR_W-1:0]           virtual_addr;
    logic                        bus_valid;
    logic                        bus_we;
    logic [DATA_W-1:0]           bus_wdata;
    logic                        bus_ack;
    logic [DATA_W-1:0]           bus_rdata;

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, bus_ack, bus_rdata,
        output m_gnt, m_ack, m_rdata, m_err, virtual_addr, bus_valid, bus_we, bus_wdata
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata, bus_ack, bus_rdata,
        input  m_gnt, m_ack, m_rdata, m_err, virtual_addr, bus_valid, bus_we, bus_wdata
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter for N_MASTERS masters. Registers the winning
// master's address, write enable and write data onto the shared bus, holds
// the grant until the slave acknowledges, then returns read data with a
// one-cycle m_ack. Optional macro BUS_TIMEOUT_EN adds a BUSY watchdog that
// aborts the transaction after TIMEOUT_CYCLES with m_err set.
module bus_arbiter #(
    parameter int N_MASTERS      = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    bus_arbiter_if.slave    bus
);
    localparam int PTR_W = $clog2(N_MASTERS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Reject out-of-range configurations at elaboration.
    if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("bus_arbiter: N_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [N_MASTERS-1:0]   gnt_q, gnt_d;
    logic [N_MASTERS-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   valid_q, valid_d;
    logic                   we_q, we_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
`endif

    // Arbitration result for the current IDLE cycle.
    logic [PTR_W-1:0]       winner;
    logic                   found;
    logic [PTR_W:0]         cand;
    logic                   sel_we;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_wdata;
    logic [PTR_W-1:0]       rr_next;

    function automatic logic [N_MASTERS-1:0] onehot(input logic [PTR_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Round-robin search: first requester at or above rr_ptr, wrapping modulo N_MASTERS.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        winner    = '0;
        found     = 1'b0;
        cand      = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(N_MASTERS)) begin
                cand = cand - (PTR_W+1)'(N_MASTERS);
            end
            if (!found && bus.m_req[cand[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[PTR_W-1:0];
            end
        end
        for (int i = 0; i < N_MASTERS; i++) begin
            if (winner == PTR_W'(i)) begin
                sel_we    = bus.m_we[i];
                sel_addr  = bus.m_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.m_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // The served master drops to lowest priority.
    assign rr_next = (owner_q == PTR_W'(N_MASTERS - 1)) ? '0 : owner_q + 1'b1;

    // Next-state and registered-output logic for IDLE -> BUSY -> DONE.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (found) begin
                    owner_d = winner;
                    gnt_d   = onehot(winner);
                    addr_d  = sel_addr;
                    we_d    = sel_we;
                    wdata_d = sel_wdata;
                    valid_d = 1'b1;
                    state_d = BUSY;
`ifdef BUS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                // Bus outputs stay frozen; only bus_ack (or the watchdog) moves on.
                if (bus.bus_ack) begin
                    rdata_d = bus.bus_rdata;
                    valid_d = 1'b0;
                    gnt_d   = '0;
                    ack_d   = onehot(owner_q);
                    state_d = DONE;
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    rdata_d = '0;
                    valid_d = 1'b0;
                    gnt_d   = '0;
                    ack_d   = onehot(owner_q);
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                rr_ptr_d = rr_next;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign bus.m_gnt        = gnt_q;
    assign bus.m_ack        = ack_q;
    assign bus.m_rdata      = rdata_q;
    assign bus.virtual_addr = addr_q;
    assign bus.bus_valid    = valid_q;
    assign bus.bus_we       = we_q;
    assign bus.bus_wdata    = wdata_q;
`ifdef BUS_TIMEOUT_EN
    assign bus.m_err        = err_q;
`else
    assign bus.m_err        = 1'b0;
`endif

endmodule
